ascon_sequencer: RTL and testbench

Control sequencer for the ASCON-128 encryption datapath (permutation + XOR stage, state register, cipher and tag registers). It walks one message through initialisation (p12), associated-data absorption (p6 per block), plaintext encryption (p6 per block) and finalisation (p12). It owns the round and block counters and a valid/ready input handshake, and drives every enable and select of the datapath, one permutation round per clock.

---
 rtl/ascon_pack.sv | 19 +
 rtl/ascon_round_cnt.sv | 38 +++
 rtl/ascon_sequencer.sv | 177 +++++++++++++++++
 tb/tb_ascon_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pack.sv
// Shared types and round-index constants for the ASCON-128 control sequencer.
package ascon_pack;

   typedef enum logic [2:0] {
      StIdle,
      StInit,
      StWaitAd,
      StAd,
      StWaitPt,
      StPt,
      StFinal,
      StDone
   } type_ctrl_state;

   localparam logic [3:0] ROUND_P12_START = 4'd0;
   localparam logic [3:0] ROUND_P6_START  = 4'd6;
   localparam logic [3:0] ROUND_LAST      = 4'd11;

endpackage

// File: rtl/ascon_round_cnt.sv
// 4-bit permutation round counter; reloads to the p12 or p6 start index, otherwise counts up.
module ascon_round_cnt
   import ascon_pack::*;
(
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic       load0_i,
   input  logic       load6_i,
   input  logic       inc_i,
   output logic [3:0] count_o
);

   logic [3:0] count_q, count_d;

   // Next-count selection: reload has priority over increment.
   always_comb begin
      count_d = count_q;
      if (load0_i) begin
         count_d = ROUND_P12_START;
      end else if (load6_i) begin
         count_d = ROUND_P6_START;
      end else if (inc_i) begin
         count_d = count_q + 4'd1;
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         count_q <= ROUND_P12_START;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/ascon_sequencer.sv
// Control FSM for the ASCON-128 datapath: p12 init, p6 per AD/PT block, p12 finalisation.
module ascon_sequencer
   import ascon_pack::*;
#(
   parameter int unsigned NB_AD_BLOCKS = 1,
   parameter int unsigned NB_PT_BLOCKS = 3
) (
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic       start_i,
   input  logic       data_valid_i,
   output logic       data_ready_o,
   output logic [3:0] round_o,
   output logic [3:0] block_o,
   output logic       data_sel_o,
   output logic       en_reg_state_o,
   output logic       en_xor_data_begin_o,
   output logic       en_xor_key_begin_o,
   output logic       en_xor_key_end_o,
   output logic       en_xor_lsb_end_o,
   output logic       en_cipher_o,
   output logic       en_tag_o,
   output logic       cipher_valid_o,
   output logic       end_o
);

   localparam logic [3:0] AD_LAST = 4'(NB_AD_BLOCKS - 1);
   localparam logic [3:0] PT_LAST = 4'(NB_PT_BLOCKS - 1);

   type_ctrl_state state_q, state_d;
   logic [3:0]     round_q, block_q, block_d;
   logic           cnt_load0, cnt_load6, cnt_inc;
   logic           cipher_valid_q, end_q, end_d;

   ascon_round_cnt u_round_cnt (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .load0_i (cnt_load0),
      .load6_i (cnt_load6),
      .inc_i   (cnt_inc),
      .count_o (round_q)
   );

   // Next-state, counter control and datapath enables from (state, round, block, data_valid_i).
   always_comb begin
      state_d             = state_q;
      block_d             = block_q;
      cnt_load0           = 1'b0;
      cnt_load6           = 1'b0;
      cnt_inc             = 1'b0;
      data_ready_o        = 1'b0;
      round_o             = round_q;
      data_sel_o          = 1'b0;
      en_reg_state_o      = 1'b0;
      en_xor_data_begin_o = 1'b0;
      en_xor_key_begin_o  = 1'b0;
      en_xor_key_end_o    = 1'b0;
      en_xor_lsb_end_o    = 1'b0;
      en_cipher_o         = 1'b0;
      en_tag_o            = 1'b0;
      end_d               = end_q;
      case (state_q)
         StIdle, StDone: begin
            if (start_i) begin
               state_d   = StInit;
               block_d   = 4'd0;
               cnt_load0 = 1'b1;
               end_d     = 1'b0;
            end
         end
         StInit: begin
            en_reg_state_o = 1'b1;
            data_sel_o     = (round_q == ROUND_P12_START);
            if (round_q == ROUND_LAST) begin
               en_xor_key_end_o = 1'b1;
               state_d          = StWaitAd;
               cnt_load6        = 1'b1;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         StWaitAd: begin
            data_ready_o = 1'b1;
            // Counter already sits at 6; hide it until the handshake round.
            round_o      = data_valid_i ? round_q : 4'd0;
            if (data_valid_i) begin
               en_reg_state_o      = 1'b1;
               en_xor_data_begin_o = 1'b1;
               cnt_inc             = 1'b1;
               state_d             = StAd;
            end
         end
         StAd: begin
            en_reg_state_o = 1'b1;
            if (round_q == ROUND_LAST) begin
               if (block_q == AD_LAST) begin
                  en_xor_lsb_end_o = 1'b1;
                  block_d          = 4'd0;
                  state_d          = StWaitPt;
                  // A single PT block is also the last one: its handshake is final round 0.
                  cnt_load0        = (PT_LAST == 4'd0);
                  cnt_load6        = (PT_LAST != 4'd0);
               end else begin
                  block_d   = block_q + 4'd1;
                  state_d   = StWaitAd;
                  cnt_load6 = 1'b1;
               end
            end else begin
               cnt_inc = 1'b1;
            end
         end
         StWaitPt: begin
            data_ready_o = 1'b1;
            round_o      = data_valid_i ? round_q : 4'd0;
            if (data_valid_i) begin
               en_reg_state_o      = 1'b1;
               en_xor_data_begin_o = 1'b1;
               en_cipher_o         = 1'b1;
               cnt_inc             = 1'b1;
               if (block_q == PT_LAST) begin
                  en_xor_key_begin_o = 1'b1;
                  block_d            = 4'd0;
                  state_d            = StFinal;
               end else begin
                  state_d = StPt;
               end
            end
         end
         StPt: begin
            en_reg_state_o = 1'b1;
            if (round_q == ROUND_LAST) begin
               block_d   = block_q + 4'd1;
               state_d   = StWaitPt;
               cnt_load0 = ((block_q + 4'd1) == PT_LAST);
               cnt_load6 = ((block_q + 4'd1) != PT_LAST);
            end else begin
               cnt_inc = 1'b1;
            end
         end
         StFinal: begin
            en_reg_state_o = 1'b1;
            if (round_q == ROUND_LAST) begin
               en_xor_key_end_o = 1'b1;
               en_tag_o         = 1'b1;
               end_d            = 1'b1;
               state_d          = StDone;
               cnt_load0        = 1'b1;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State, block counter and registered status flags.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q        <= StIdle;
         block_q        <= 4'd0;
         cipher_valid_q <= 1'b0;
         end_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         block_q        <= block_d;
         cipher_valid_q <= en_cipher_o;
         end_q          <= end_d;
      end
   end

   assign block_o        = block_q;
   assign cipher_valid_o = cipher_valid_q;
   assign end_o          = end_q;

endmodule

// File: tb/tb_ascon_sequencer.sv
// Scoreboard bench for ascon_sequencer: default instance plus a 2-AD / 1-PT instance.
module tb_ascon_sequencer;

   typedef struct packed {
      logic       ready;
      logic [3:0] round;
      logic [3:0] block;
      logic       data_sel;
      logic       en_reg;
      logic       xdb;
      logic       xkb;
      logic       xke;
      logic       xle;
      logic       en_cipher;
      logic       en_tag;
      logic       cv;
      logic       done;
   } obs_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0;
   logic valid = 1'b0;
   logic sel = 1'b0;
   obs_t o0, o1, obs;

   int errs = 0;
   int checks = 0;

   int q_hs[$];
   int q_rnd[$];
   int q_cv[$];
   int q_tag[$];
   int q_lsb[$];
   int exp_end;

   always #5 clk = ~clk;

   logic r0, dsel0, er0, xdb0, xkb0, xke0, xle0, ec0, et0, cv0, e0;
   logic [3:0] rd0, bk0;
   logic r1, dsel1, er1, xdb1, xkb1, xke1, xle1, ec1, et1, cv1, e1;
   logic [3:0] rd1, bk1;

   ascon_sequencer u_dut0 (
      .clock_i(clk), .reset_i(reset), .start_i(start && !sel), .data_valid_i(valid && !sel),
      .data_ready_o(r0), .round_o(rd0), .block_o(bk0), .data_sel_o(dsel0),
      .en_reg_state_o(er0), .en_xor_data_begin_o(xdb0), .en_xor_key_begin_o(xkb0),
      .en_xor_key_end_o(xke0), .en_xor_lsb_end_o(xle0), .en_cipher_o(ec0), .en_tag_o(et0),
      .cipher_valid_o(cv0), .end_o(e0)
   );

   ascon_sequencer #(.NB_AD_BLOCKS(2), .NB_PT_BLOCKS(1)) u_dut1 (
      .clock_i(clk), .reset_i(reset), .start_i(start && sel), .data_valid_i(valid && sel),
      .data_ready_o(r1), .round_o(rd1), .block_o(bk1), .data_sel_o(dsel1),
      .en_reg_state_o(er1), .en_xor_data_begin_o(xdb1), .en_xor_key_begin_o(xkb1),
      .en_xor_key_end_o(xke1), .en_xor_lsb_end_o(xle1), .en_cipher_o(ec1), .en_tag_o(et1),
      .cipher_valid_o(cv1), .end_o(e1)
   );

   assign o0 = {r0, rd0, bk0, dsel0, er0, xdb0, xkb0, xke0, xle0, ec0, et0, cv0, e0};
   assign o1 = {r1, rd1, bk1, dsel1, er1, xdb1, xkb1, xke1, xle1, ec1, et1, cv1, e1};
   assign obs = sel ? o1 : o0;

   // Runs one message and checks every event against the schedule predicted from its shape.
   task automatic run_msg(input bit s, input int nb_ad, input int nb_pt, input int w,
                          input bit glitch);
      int c, hs, wcnt, cyc, exp;
      bit end_seen;
      q_hs.delete(); q_rnd.delete(); q_cv.delete(); q_tag.delete(); q_lsb.delete();
      c = 13;
      for (int a = 0; a < nb_ad; a++) begin
         hs = c + w;
         q_hs.push_back(hs);
         q_rnd.push_back(6);
         if (a == nb_ad - 1) q_lsb.push_back(hs + 5);
         c = hs + 6;
      end
      for (int p = 0; p < nb_pt; p++) begin
         hs = c + w;
         q_hs.push_back(hs);
         q_cv.push_back(hs + 1);
         if (p < nb_pt - 1) begin
            q_rnd.push_back(6);
            c = hs + 6;
         end else begin
            q_rnd.push_back(0);
            q_tag.push_back(hs + 11);
            exp_end = hs + 12;
         end
      end
      sel = s;
      @(posedge clk); #1;
      start = 1'b1;
      valid = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1;
      wcnt = 0;
      end_seen = 1'b0;
      while (!end_seen && cyc < 200) begin
         start = glitch && (cyc == 20);
         valid = !(obs.ready && wcnt < w);
         if (obs.ready && wcnt < w) wcnt++;
         #1;
         if (cyc == 1) begin
            checks++;
            if (obs.data_sel !== 1'b1 || obs.round !== 4'd0 || obs.en_reg !== 1'b1) begin
               errs++;
               $display("FAIL init_first: sel=%0b round=%0d en_reg=%0b, required 1 0 1",
                        obs.data_sel, obs.round, obs.en_reg);
            end
         end
         if (cyc == 12) begin
            checks++;
            if (obs.round !== 4'd11 || obs.xke !== 1'b1 || obs.data_sel !== 1'b0) begin
               errs++;
               $display("FAIL init_last: round=%0d key_end=%0b sel=%0b, required 11 1 0",
                        obs.round, obs.xke, obs.data_sel);
            end
         end
         if (obs.ready && !valid) begin
            checks++;
            if (obs.round !== 4'd0 || obs.en_reg !== 1'b0 || obs.xdb !== 1'b0) begin
               errs++;
               $display("FAIL wait_idle cyc %0d: round=%0d en_reg=%0b xdb=%0b, required 0 0 0",
                        cyc, obs.round, obs.en_reg, obs.xdb);
            end
         end
         if (obs.ready && valid) begin
            wcnt = 0;
            checks++;
            if (q_hs.size() == 0) begin
               errs++;
               $display("FAIL handshake: unexpected at cyc %0d, required none", cyc);
            end else begin
               exp = q_hs.pop_front();
               c = q_rnd.pop_front();
               if (cyc != exp || obs.round !== 4'(c) || obs.xkb !== (c == 0) ||
                   obs.xdb !== 1'b1 || obs.en_reg !== 1'b1) begin
                  errs++;
                  $display("FAIL handshake: cyc=%0d round=%0d key_begin=%0b, required %0d %0d %0b",
                           cyc, obs.round, obs.xkb, exp, c, (c == 0));
               end
            end
         end
         if (obs.cv) begin
            checks++;
            exp = (q_cv.size() != 0) ? q_cv.pop_front() : -1;
            if (cyc != exp) begin
               errs++;
               $display("FAIL cipher_valid: cyc=%0d, required %0d", cyc, exp);
            end
         end
         if (obs.xle) begin
            checks++;
            exp = (q_lsb.size() != 0) ? q_lsb.pop_front() : -1;
            if (cyc != exp) begin
               errs++;
               $display("FAIL lsb_end: cyc=%0d, required %0d", cyc, exp);
            end
         end
         if (obs.en_tag) begin
            checks++;
            exp = (q_tag.size() != 0) ? q_tag.pop_front() : -1;
            if (cyc != exp || obs.round !== 4'd11 || obs.xke !== 1'b1) begin
               errs++;
               $display("FAIL tag: cyc=%0d round=%0d key_end=%0b, required %0d 11 1",
                        cyc, obs.round, obs.xke, exp);
            end
         end
         if (obs.done) begin
            end_seen = 1'b1;
            checks++;
            if (cyc != exp_end) begin
               errs++;
               $display("FAIL end: cyc=%0d, required %0d", cyc, exp_end);
            end
         end
         if (!end_seen) begin
            @(posedge clk); #1;
            cyc++;
         end
      end
      start = 1'b0;
      checks++;
      if (!end_seen) begin
         errs++;
         $display("FAIL end_timeout: no end_o within %0d cycles, required %0d", cyc, exp_end);
      end
      checks++;
      if (q_hs.size() + q_cv.size() + q_tag.size() + q_lsb.size() != 0) begin
         errs++;
         $display("FAIL leftover: %0d expected events unseen, required 0",
                  q_hs.size() + q_cv.size() + q_tag.size() + q_lsb.size());
      end
   endtask

   task automatic test_reset();
      sel = 1'b0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (o0 !== '0 || o1 !== '0) begin
         errs++;
         $display("FAIL reset_outputs: %h/%h, required 0", o0, o1);
      end
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if (o0 !== '0) begin
            errs++;
            $display("FAIL idle_outputs: %h, required 0", o0);
         end
      end
      valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (o0 !== '0) begin
            errs++;
            $display("FAIL idle_valid: %h, required 0", o0);
         end
      end
      valid = 1'b0;
   endtask

   task automatic test_default();
      run_msg(1'b0, 1, 3, 0, 1'b1);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (o0.done !== 1'b1) begin
            errs++;
            $display("FAIL end_hold: end_o=%0b, required 1", o0.done);
         end
      end
      run_msg(1'b0, 1, 3, 0, 1'b0);
   endtask

   task automatic test_withheld();
      run_msg(1'b0, 1, 3, 4, 1'b0);
   endtask

   task automatic test_multi_ad();
      run_msg(1'b1, 2, 1, 0, 1'b0);
   endtask

   task automatic test_reset_in_final();
      int cyc;
      bit bad;
      sel = 1'b0;
      @(posedge clk); #1;
      start = 1'b1;
      valid = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (cyc = 1; cyc < 36; cyc++) begin
         @(posedge clk); #1;
      end
      checks++;
      if (o0.round !== 4'd5 || o0.en_reg !== 1'b1) begin
         errs++;
         $display("FAIL final_round5: round=%0d en_reg=%0b, required 5 1", o0.round, o0.en_reg);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++;
      if (o0 !== '0) begin
         errs++;
         $display("FAIL reset_mid: %h, required 0", o0);
      end
      bad = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (o0.en_tag || o0.done || o0.cv) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errs++;
         $display("FAIL reset_partial: tag/end/cv seen after reset, required none");
      end
      valid = 1'b0;
      run_msg(1'b0, 1, 3, 0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_default();
      test_back_to_back();
      test_withheld();
      test_multi_ad();
      test_reset_in_final();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
